// File: rtl/gray_rx_checker_pkg.sv
// gray_rx_pkg: shared types and defaults for the Gray-count receive checker.
//   state_e   - checker FSM state (UNLOCKED, ACQUIRE, LOCKED), 2-bit encoding
//   DEF_*     - default parameter values for the checker and its interface
//   gray2bin  - behavioural Gray-to-binary decode for up to 32-bit values
package gray_rx_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_e;

  localparam int DEF_WIDTH    = 5;
  localparam int DEF_LOCK_CNT = 4;
  localparam int DEF_LOSS_CNT = 2;
  localparam int DEF_ERR_W    = 8;

  // Prefix-XOR from the MSB down. Bits above the real width must be zero.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int s = 1; s < 32; s = s << 1) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_rx_checker_if.sv
// gray_rx_checker_if: bundle between a Gray-count producer side and the checker.
//   enable    - data_in holds a valid sample this cycle
//   data_in   - Gray-coded count
//   clr_err   - synchronous clear of err_count
//   bin_out   - decoded binary of the last accepted sample
//   bin_valid - one-cycle pulse, bin_out updated at this edge
//   error     - one-cycle pulse, sequence error while locked
//   locked    - high while the checker is LOCKED
//   err_count - saturating error count
//   state     - debug view of the checker FSM state
//
// Handshake: enable is a plain valid qualifier with no ready/backpressure; the
// checker accepts every sample presented with enable=1 at that clock edge, and
// results appear one clock later qualified by bin_valid.
interface gray_rx_checker_if
  import gray_rx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ERR_W = DEF_ERR_W
);
  logic             enable;
  logic [WIDTH-1:0] data_in;
  logic             clr_err;
  logic [WIDTH-1:0] bin_out;
  logic             bin_valid;
  logic             error;
  logic             locked;
  logic [ERR_W-1:0] err_count;
  state_e           state;

  modport master (
    output enable, data_in, clr_err,
    input  bin_out, bin_valid, error, locked, err_count, state
  );

  modport slave (
    input  enable, data_in, clr_err,
    output bin_out, bin_valid, error, locked, err_count, state
  );
endinterface

// File: rtl/gray_rx_checker_gray2bin.sv
// gray2bin_comb: combinational Gray-to-binary decoder.
//   gray_i - Gray-coded input, WIDTH bits
//   bin_o  - binary output; bin_o[i] is the XOR of gray_i[WIDTH-1:i]
module gray2bin_comb #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);
  // Each output bit is an independent reduction, so there is no ripple chain
  // through bin_o itself.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[WIDTH-1:i];
  end
endmodule

// File: rtl/gray_rx_checker.sv
// gray_rx_checker: samples a Gray-coded count when enabled, decodes it, checks
// that each sample is the previous one plus one (mod 2^WIDTH), tracks lock and
// counts sequence errors.
//   clk   - rising-edge clock
//   reset - asynchronous, active-high reset
//   bus   - gray_rx_checker_if slave: enable/data_in/clr_err in;
//           bin_out/bin_valid/error/locked/err_count/state out
module gray_rx_checker
  import gray_rx_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int LOSS_CNT = DEF_LOSS_CNT,
  parameter int ERR_W    = DEF_ERR_W
) (
  input logic               clk,
  input logic               reset,
  gray_rx_checker_if.slave  bus
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);
  localparam logic [MW-1:0]    LOCK_V  = MW'(LOCK_CNT);
  localparam logic [LW-1:0]    LOSS_V  = LW'(LOSS_CNT);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_e           state_q;
  logic [WIDTH-1:0] last_bin_q;
  logic [WIDTH-1:0] bin_out_q;
  logic             bin_valid_q;
  logic             error_q;
  logic             locked_q;
  logic [ERR_W-1:0] err_count_q;
  logic [ERR_W-1:0] err_count_d;
  logic [MW-1:0]    match_cnt_q;
  logic [LW-1:0]    miss_cnt_q;

  logic [WIDTH-1:0] dec;
  logic [WIDTH-1:0] exp_bin;
  logic             seq_ok;
  logic             err_hit;
  logic [MW-1:0]    match_inc;
  logic [LW-1:0]    miss_inc;

  gray2bin_comb #(.WIDTH(WIDTH)) u_dec (
    .gray_i (bus.data_in),
    .bin_o  (dec)
  );

  always_comb begin
    exp_bin   = last_bin_q + WIDTH'(1);  // truncation gives the all-ones -> 0 wrap
    seq_ok    = (dec == exp_bin);
    err_hit   = bus.enable && (state_q == LOCKED) && !seq_ok;
    match_inc = match_cnt_q + MW'(1);
    miss_inc  = miss_cnt_q + LW'(1);

    // Clear wins over the old count, but an error on the same edge still counts.
    err_count_d = err_count_q;
    if (bus.clr_err) begin
      err_count_d = err_hit ? ERR_W'(1) : '0;
    end else if (err_hit && (err_count_q != ERR_MAX)) begin
      err_count_d = err_count_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= UNLOCKED;
      last_bin_q  <= '0;
      bin_out_q   <= '0;
      bin_valid_q <= 1'b0;
      error_q     <= 1'b0;
      locked_q    <= 1'b0;
      err_count_q <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
    end else begin
      bin_valid_q <= 1'b0;
      error_q     <= 1'b0;
      err_count_q <= err_count_d;
      if (bus.enable) begin
        bin_out_q   <= dec;
        bin_valid_q <= 1'b1;
        last_bin_q  <= dec;  // every accepted sample becomes the new base
        case (state_q)
          UNLOCKED: begin
            match_cnt_q <= '0;
            state_q     <= ACQUIRE;
            locked_q    <= 1'b0;
          end
          ACQUIRE: begin
            if (seq_ok) begin
              match_cnt_q <= match_inc;
              if (match_inc == LOCK_V) begin
                state_q    <= LOCKED;
                locked_q   <= 1'b1;
                miss_cnt_q <= '0;
              end
            end else begin
              match_cnt_q <= '0;
            end
          end
          LOCKED: begin
            if (seq_ok) begin
              miss_cnt_q <= '0;
            end else begin
              error_q <= 1'b1;
              if (miss_inc == LOSS_V) begin
                state_q    <= UNLOCKED;
                locked_q   <= 1'b0;
                miss_cnt_q <= '0;
              end else begin
                miss_cnt_q <= miss_inc;
              end
            end
          end
          default: begin
            state_q  <= UNLOCKED;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.bin_out   = bin_out_q;
  assign bus.bin_valid = bin_valid_q;
  assign bus.error     = error_q;
  assign bus.locked    = locked_q;
  assign bus.err_count = err_count_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_gray_rx_checker.sv
// Directed bench for gray_rx_checker (WIDTH=5, LOCK_CNT=4, LOSS_CNT=2, ERR_W=8).
module tb_gray_rx_checker;
  import gray_rx_pkg::*;

  logic clk;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  logic [4:0] exp_q[$];

  gray_rx_checker_if #(.WIDTH(5), .ERR_W(8)) bus ();

  gray_rx_checker #(
    .WIDTH(5), .LOCK_CNT(4), .LOSS_CNT(2), .ERR_W(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus-side binary-to-Gray encoder.
  function automatic logic [4:0] to_gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Drive one cycle at the falling edge, check #1 after the rising edge.
  task automatic step(input string tag, input logic en, input logic [4:0] g,
                      input logic clr, input logic [4:0] exp_bin,
                      input logic exp_err, input logic exp_lk, input logic [7:0] exp_ec);
    @(negedge clk);
    bus.enable  = en;
    bus.data_in = g;
    bus.clr_err = clr;
    exp_q.push_back(exp_bin);
    @(posedge clk);
    #1;
    chk({tag, ".bin_valid"}, bus.bin_valid, en);
    chk({tag, ".bin_out"}, bus.bin_out, exp_q.pop_front());
    chk({tag, ".error"}, bus.error, exp_err);
    chk({tag, ".locked"}, bus.locked, exp_lk);
    chk({tag, ".err_count"}, bus.err_count, exp_ec);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".bin_out"}, bus.bin_out, 0);
    chk({tag, ".bin_valid"}, bus.bin_valid, 0);
    chk({tag, ".error"}, bus.error, 0);
    chk({tag, ".locked"}, bus.locked, 0);
    chk({tag, ".err_count"}, bus.err_count, 0);
    chk({tag, ".state"}, bus.state, UNLOCKED);
  endtask

  initial begin
    logic [4:0] cur;
    int ec;
    reset       = 1'b0;
    bus.enable  = 1'b0;
    bus.data_in = '0;
    bus.clr_err = 1'b0;

    // 1. Asynchronous reset mid-cycle (t=12, between edges at 5/10 and 15).
    #12;
    reset = 1'b1;
    #1;
    chk_reset_outputs("rst_async");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step("rst_idle", 1'b0, 5'b00000, 1'b0, 5'd0, 1'b0, 1'b0, 8'd0);

    // 2. Acquire: bin 0..4, lock at the fifth sample.
    step("acq0", 1'b1, 5'b00000, 1'b0, 5'd0, 1'b0, 1'b0, 8'd0);
    step("acq1", 1'b1, 5'b00001, 1'b0, 5'd1, 1'b0, 1'b0, 8'd0);
    step("acq2", 1'b1, 5'b00011, 1'b0, 5'd2, 1'b0, 1'b0, 8'd0);
    step("acq3", 1'b1, 5'b00010, 1'b0, 5'd3, 1'b0, 1'b0, 8'd0);
    step("acq4", 1'b1, 5'b00110, 1'b0, 5'd4, 1'b0, 1'b1, 8'd0);
    chk("acq4.state", bus.state, LOCKED);

    // 3. Walk up to 29, then wrap 30, 31, 0.
    for (int b = 5; b < 30; b++) step("walk", 1'b1, to_gray(5'(b)), 1'b0, 5'(b), 1'b0, 1'b1, 8'd0);
    step("wrap30", 1'b1, 5'b10001, 1'b0, 5'd30, 1'b0, 1'b1, 8'd0);
    step("wrap31", 1'b1, 5'b10000, 1'b0, 5'd31, 1'b0, 1'b1, 8'd0);
    step("wrap0",  1'b1, 5'b00000, 1'b0, 5'd0,  1'b0, 1'b1, 8'd0);

    // 4. Single skip 5 -> 7, then 8 is good.
    for (int b = 1; b < 6; b++) step("walk2", 1'b1, to_gray(5'(b)), 1'b0, 5'(b), 1'b0, 1'b1, 8'd0);
    step("skip7", 1'b1, 5'b00100, 1'b0, 5'd7, 1'b1, 1'b1, 8'd1);
    step("after8", 1'b1, 5'b01100, 1'b0, 5'd8, 1'b0, 1'b1, 8'd1);

    // 5. Two bad in a row drop lock; 26..30 relock.
    step("bad20", 1'b1, to_gray(5'd20), 1'b0, 5'd20, 1'b1, 1'b1, 8'd2);
    step("bad25", 1'b1, to_gray(5'd25), 1'b0, 5'd25, 1'b1, 1'b0, 8'd3);
    chk("bad25.state", bus.state, UNLOCKED);
    step("re26", 1'b1, to_gray(5'd26), 1'b0, 5'd26, 1'b0, 1'b0, 8'd3);
    step("re27", 1'b1, to_gray(5'd27), 1'b0, 5'd27, 1'b0, 1'b0, 8'd3);
    step("re28", 1'b1, to_gray(5'd28), 1'b0, 5'd28, 1'b0, 1'b0, 8'd3);
    step("re29", 1'b1, to_gray(5'd29), 1'b0, 5'd29, 1'b0, 1'b0, 8'd3);
    step("re30", 1'b1, to_gray(5'd30), 1'b0, 5'd30, 1'b0, 1'b1, 8'd3);

    // 6a. Gap of three idle cycles (data_in garbage), then 31 accepted.
    for (int i = 0; i < 3; i++) step("gap", 1'b0, 5'b11111, 1'b0, 5'd30, 1'b0, 1'b1, 8'd3);
    step("gap31", 1'b1, to_gray(5'd31), 1'b0, 5'd31, 1'b0, 1'b1, 8'd3);

    // 6b. Clear coinciding with an error leaves 1; clear alone gives 0.
    step("clr_err_hit", 1'b1, to_gray(5'd5), 1'b1, 5'd5, 1'b1, 1'b1, 8'd1);
    step("good6", 1'b1, to_gray(5'd6), 1'b0, 5'd6, 1'b0, 1'b1, 8'd1);
    step("clr_only", 1'b0, 5'b00000, 1'b1, 5'd6, 1'b0, 1'b1, 8'd0);

    // 6c. 300 isolated errors (each followed by a good sample) saturate at 255.
    cur = 5'd6;
    for (int k = 0; k < 300; k++) begin
      ec = (k + 1 > 255) ? 255 : k + 1;
      cur = cur + 5'd2;
      step("sat_bad", 1'b1, to_gray(cur), 1'b0, cur, 1'b1, 1'b1, 8'(ec));
      cur = cur + 5'd1;
      step("sat_good", 1'b1, to_gray(cur), 1'b0, cur, 1'b0, 1'b1, 8'(ec));
    end
    chk("sat.final", bus.err_count, 255);

    // Reset again mid-cycle from a busy, locked, saturated state.
    @(negedge clk);
    bus.enable = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk_reset_outputs("rst_busy");
    bus.enable = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
